store_checker: RTL and testbench

- Reusable, synthesizable store-stream checker that sits beside `top` in the bench (or on an FPGA debug harness).
- Snoops the data-memory write port (MemWrite/DataAdr/WriteData) and compares each store against a programmable ordered table of expected (address, data) pairs.
- Programmable "scratch" addresses are ignored.
- Produces sticky pass/fail flags with a failure code and capture registers.
- Replaces the hard-coded single-pair negedge check with a parametrised, timed, multi-entry check.

---
 rtl/store_checker_pkg.sv | 24 ++
 rtl/store_exp_table.sv | 30 +++
 rtl/store_checker.sv | 177 +++++++++++++++++
 tb/tb_store_checker.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/store_checker_pkg.sv
// Shared types and constants for the store-stream checker.
package store_checker_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_PASS,
      ST_FAIL
   } state_t;

   localparam logic [1:0] FC_NONE          = 2'd0;
   localparam logic [1:0] FC_UNEXP_ADDR    = 2'd1;
   localparam logic [1:0] FC_DATA_MISMATCH = 2'd2;
   localparam logic [1:0] FC_TIMEOUT       = 2'd3;

   localparam int unsigned DEF_XLEN = 32;

   // Default entry layout; users with another XLEN pass their own entry type.
   typedef struct packed {
      logic [DEF_XLEN-1:0] addr;
      logic [DEF_XLEN-1:0] data;
   } store_entry_t;

endpackage

// File: rtl/store_exp_table.sv
// Expected-store table: synchronous write port, combinational read at the check pointer.
module store_exp_table
   import store_checker_pkg::*;
#(
   parameter int unsigned XLEN  = DEF_XLEN,
   parameter int unsigned DEPTH = 8,
   parameter int unsigned IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   parameter type         entry_t = store_entry_t
) (
   input  logic            clk,
   input  logic            we,
   input  logic [IW-1:0]   wr_idx,
   input  logic [XLEN-1:0] wr_addr,
   input  logic [XLEN-1:0] wr_data,
   input  logic [IW-1:0]   rd_idx,
   output entry_t          rd_entry
);

   entry_t mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we && (32'(wr_idx) < DEPTH)) begin
         mem[wr_idx].addr <= wr_addr;
         mem[wr_idx].data <= wr_data;
      end
   end

   assign rd_entry = (32'(rd_idx) < DEPTH) ? mem[rd_idx] : '0;

endmodule

// File: rtl/store_checker.sv
// Snoops the data-memory write port and checks stores against an ordered expected table,
// skipping enabled scratch addresses; reports sticky pass/fail with capture registers.
module store_checker
   import store_checker_pkg::*;
#(
   parameter int unsigned XLEN    = 32,
   parameter int unsigned DEPTH   = 8,
   parameter int unsigned NSCR    = 2,
   parameter int unsigned TIMEOUT = 1024,
   localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int unsigned CW = $clog2(DEPTH + 1),
   localparam int unsigned SW = (NSCR > 1) ? $clog2(NSCR) : 1,
   localparam int unsigned TW = $clog2(TIMEOUT + 1)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            cfg_we,
   input  logic [IW-1:0]   cfg_idx,
   input  logic [XLEN-1:0] cfg_addr,
   input  logic [XLEN-1:0] cfg_data,
   input  logic [CW-1:0]   cfg_count,
   input  logic            scr_we,
   input  logic [SW-1:0]   scr_idx,
   input  logic [XLEN-1:0] scr_addr,
   input  logic            scr_en,
   input  logic            start,
   input  logic            MemWrite,
   input  logic [XLEN-1:0] DataAdr,
   input  logic [XLEN-1:0] WriteData,
   output logic            busy,
   output logic            pass,
   output logic            fail,
   output logic [1:0]      fail_code,
   output logic [XLEN-1:0] fail_addr,
   output logic [XLEN-1:0] fail_data,
   output logic [CW-1:0]   match_cnt
);

   typedef struct packed {
      logic [XLEN-1:0] addr;
      logic [XLEN-1:0] data;
   } entry_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   count_q, count_d;
   logic [CW-1:0]   match_cnt_q, match_cnt_d;
   logic [TW-1:0]   cyc_q, cyc_d;
   logic [1:0]      fail_code_q, fail_code_d;
   logic [XLEN-1:0] fail_addr_q, fail_addr_d;
   logic [XLEN-1:0] fail_data_q, fail_data_d;

   logic            cfg_open;
   entry_t          exp_entry;
   logic            addr_hit, data_hit, scr_hit, resolved;

   logic [XLEN-1:0] scr_addr_q [NSCR];
   logic [NSCR-1:0] scr_en_q;

   assign cfg_open = (state_q != ST_RUN);

   // The pointer into the table is the number of entries already matched.
   store_exp_table #(
      .XLEN    (XLEN),
      .DEPTH   (DEPTH),
      .IW      (IW),
      .entry_t (entry_t)
   ) u_table (
      .clk      (clk),
      .we       (cfg_we && cfg_open),
      .wr_idx   (cfg_idx),
      .wr_addr  (cfg_addr),
      .wr_data  (cfg_data),
      .rd_idx   (IW'(match_cnt_q)),
      .rd_entry (exp_entry)
   );

   always_ff @(posedge clk) begin
      if (!rst_n)
         scr_en_q <= '0;
      else if (scr_we && cfg_open && (32'(scr_idx) < NSCR))
         scr_en_q[scr_idx] <= scr_en;
   end

   always_ff @(posedge clk) begin
      if (scr_we && cfg_open && (32'(scr_idx) < NSCR))
         scr_addr_q[scr_idx] <= scr_addr;
   end

   always_comb begin
      scr_hit = 1'b0;
      for (int unsigned i = 0; i < NSCR; i++) begin
         if (scr_en_q[i] && (scr_addr_q[i] == DataAdr))
            scr_hit = 1'b1;
      end
   end

   assign addr_hit = (DataAdr == exp_entry.addr);
   assign data_hit = (WriteData == exp_entry.data);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         count_q     <= '0;
         match_cnt_q <= '0;
         cyc_q       <= '0;
         fail_code_q <= FC_NONE;
         fail_addr_q <= '0;
         fail_data_q <= '0;
      end else begin
         state_q     <= state_d;
         count_q     <= count_d;
         match_cnt_q <= match_cnt_d;
         cyc_q       <= cyc_d;
         fail_code_q <= fail_code_d;
         fail_addr_q <= fail_addr_d;
         fail_data_q <= fail_data_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      count_d     = count_q;
      match_cnt_d = match_cnt_q;
      cyc_d       = cyc_q;
      fail_code_d = fail_code_q;
      fail_addr_d = fail_addr_q;
      fail_data_d = fail_data_q;
      resolved    = 1'b0;
      unique case (state_q)
         ST_RUN: begin
            cyc_d = cyc_q + TW'(1);
            if (MemWrite) begin
               if (addr_hit && data_hit) begin
                  match_cnt_d = match_cnt_q + CW'(1);
                  if (match_cnt_d == count_q) begin
                     state_d  = ST_PASS;
                     resolved = 1'b1;
                  end
               end else if (!scr_hit) begin
                  state_d     = ST_FAIL;
                  fail_code_d = addr_hit ? FC_DATA_MISMATCH : FC_UNEXP_ADDR;
                  fail_addr_d = DataAdr;
                  fail_data_d = WriteData;
                  resolved    = 1'b1;
               end
            end
            // A store that decides the run on the limit edge takes precedence over timeout.
            if (!resolved && (cyc_q == TW'(TIMEOUT - 1))) begin
               state_d     = ST_FAIL;
               fail_code_d = FC_TIMEOUT;
               fail_addr_d = '0;
               fail_data_d = '0;
            end
         end
         default: begin
            if (start) begin
               count_d     = cfg_count;
               match_cnt_d = '0;
               cyc_d       = '0;
               fail_code_d = FC_NONE;
               fail_addr_d = '0;
               fail_data_d = '0;
               state_d     = (cfg_count == '0) ? ST_PASS : ST_RUN;
            end
         end
      endcase
   end

   assign busy      = (state_q == ST_RUN);
   assign pass      = (state_q == ST_PASS);
   assign fail      = (state_q == ST_FAIL);
   assign fail_code = fail_code_q;
   assign fail_addr = fail_addr_q;
   assign fail_data = fail_data_q;
   assign match_cnt = match_cnt_q;

endmodule

// File: tb/tb_store_checker.sv
// Directed and randomized bench for store_checker against a queue-based reference model.
module tb_store_checker;

   localparam int TO = 16;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cfg_we;
   logic [2:0]  cfg_idx;
   logic [31:0] cfg_addr, cfg_data;
   logic [3:0]  cfg_count;
   logic        scr_we;
   logic [0:0]  scr_idx;
   logic [31:0] scr_addr;
   logic        scr_en;
   logic        start;
   logic        MemWrite;
   logic [31:0] DataAdr, WriteData;
   logic        busy, pass, fail;
   logic [1:0]  fail_code;
   logic [31:0] fail_addr, fail_data;
   logic [3:0]  match_cnt;

   always #5 clk = ~clk;

   store_checker #(
      .XLEN    (32),
      .DEPTH   (8),
      .NSCR    (2),
      .TIMEOUT (TO)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cfg_we    (cfg_we),
      .cfg_idx   (cfg_idx),
      .cfg_addr  (cfg_addr),
      .cfg_data  (cfg_data),
      .cfg_count (cfg_count),
      .scr_we    (scr_we),
      .scr_idx   (scr_idx),
      .scr_addr  (scr_addr),
      .scr_en    (scr_en),
      .start     (start),
      .MemWrite  (MemWrite),
      .DataAdr   (DataAdr),
      .WriteData (WriteData),
      .busy      (busy),
      .pass      (pass),
      .fail      (fail),
      .fail_code (fail_code),
      .fail_addr (fail_addr),
      .fail_data (fail_data),
      .match_cnt (match_cnt)
   );

   // Reference model: the run is a queue of still-expected stores plus an elapsed-cycle count.
   localparam int M_IDLE = 0, M_RUN = 1, M_PASS = 2, M_FAIL = 3;
   typedef struct packed { logic [31:0] a; logic [31:0] d; } ent_t;

   int          m_state;
   int          m_matched, m_elapsed, m_code;
   logic [31:0] m_faddr, m_fdata;
   logic [31:0] m_tab_a [8];
   logic [31:0] m_tab_d [8];
   logic [31:0] m_scr_a [2];
   logic        m_scr_en [2];
   ent_t        exp_q [$];

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic bit is_scratch(input logic [31:0] a);
      for (int i = 0; i < 2; i++)
         if (m_scr_en[i] && m_scr_a[i] == a) return 1'b1;
      return 1'b0;
   endfunction

   task automatic set_fail(input int code, input logic [31:0] a, input logic [31:0] d);
      m_state = M_FAIL;
      m_code  = code;
      m_faddr = a;
      m_fdata = d;
   endtask

   task automatic model_edge();
      bit decided;
      if (!rst_n) begin
         m_state = M_IDLE; m_matched = 0; m_code = 0; m_faddr = '0; m_fdata = '0;
         m_scr_en[0] = 1'b0; m_scr_en[1] = 1'b0;
         return;
      end
      if (m_state != M_RUN) begin
         if (cfg_we) begin m_tab_a[cfg_idx] = cfg_addr; m_tab_d[cfg_idx] = cfg_data; end
         if (scr_we) begin m_scr_a[scr_idx] = scr_addr; m_scr_en[scr_idx] = scr_en; end
         if (start) begin
            exp_q.delete();
            for (int i = 0; i < int'(cfg_count); i++) exp_q.push_back({m_tab_a[i], m_tab_d[i]});
            m_matched = 0; m_elapsed = 0; m_code = 0; m_faddr = '0; m_fdata = '0;
            m_state = (exp_q.size() == 0) ? M_PASS : M_RUN;
         end
         return;
      end
      m_elapsed++;
      decided = 1'b0;
      if (MemWrite && exp_q.size() > 0) begin
         if (DataAdr == exp_q[0].a && WriteData == exp_q[0].d) begin
            void'(exp_q.pop_front());
            m_matched++;
            if (exp_q.size() == 0) begin m_state = M_PASS; decided = 1'b1; end
         end else if (!is_scratch(DataAdr)) begin
            set_fail((DataAdr == exp_q[0].a) ? 2 : 1, DataAdr, WriteData);
            decided = 1'b1;
         end
      end
      if (!decided && m_elapsed == TO) set_fail(3, '0, '0);
   endtask

   task automatic check_outputs();
      chk("busy",      32'(busy),      32'(m_state == M_RUN));
      chk("pass",      32'(pass),      32'(m_state == M_PASS));
      chk("fail",      32'(fail),      32'(m_state == M_FAIL));
      chk("fail_code", 32'(fail_code), 32'(m_code));
      chk("fail_addr", fail_addr,      m_faddr);
      chk("fail_data", fail_data,      m_fdata);
      chk("match_cnt", 32'(match_cnt), 32'(m_matched));
   endtask

   task automatic step();
      model_edge();
      @(posedge clk);
      #1;
      check_outputs();
      start = 1'b0; cfg_we = 1'b0; scr_we = 1'b0; MemWrite = 1'b0;
   endtask

   task automatic cfg_write(input int idx, input logic [31:0] a, input logic [31:0] d);
      cfg_we = 1'b1; cfg_idx = 3'(idx); cfg_addr = a; cfg_data = d;
      step();
   endtask

   task automatic scr_write(input int idx, input logic [31:0] a, input logic en);
      scr_we = 1'b1; scr_idx = 1'(idx); scr_addr = a; scr_en = en;
      step();
   endtask

   task automatic do_start(input int cnt);
      start = 1'b1; cfg_count = 4'(cnt);
      step();
   endtask

   task automatic store(input logic [31:0] a, input logic [31:0] d);
      MemWrite = 1'b1; DataAdr = a; WriteData = d;
      step();
   endtask

   function automatic logic [31:0] pick_addr();
      return 32'($urandom_range(0, 7)) << 2;
   endfunction

   initial begin
      rst_n = 1'b0; cfg_we = 1'b0; cfg_idx = '0; cfg_addr = '0; cfg_data = '0; cfg_count = '0;
      scr_we = 1'b0; scr_idx = '0; scr_addr = '0; scr_en = 1'b0; start = 1'b0;
      MemWrite = 1'b0; DataAdr = '0; WriteData = '0;
      m_state = M_IDLE; m_matched = 0; m_elapsed = 0; m_code = 0; m_faddr = '0; m_fdata = '0;
      for (int i = 0; i < 8; i++) begin m_tab_a[i] = '0; m_tab_d[i] = '0; end
      for (int i = 0; i < 2; i++) begin m_scr_a[i] = '0; m_scr_en[i] = 1'b0; end

      step(); step();
      chk("rst_pass", 32'(pass), 32'd0);
      chk("rst_fail", 32'(fail), 32'd0);
      rst_n = 1'b1;

      // Single entry with a scratch store before the match
      cfg_write(0, 32'd100, 32'd25);
      scr_write(0, 32'd96, 1'b1);
      do_start(1);
      store(32'd96, 32'd7);
      chk("t1_busy_after_scr", 32'(busy), 32'd1);
      store(32'd100, 32'd25);
      chk("t1_pass", 32'(pass), 32'd1);
      chk("t1_match_cnt", 32'(match_cnt), 32'd1);
      chk("t1_busy", 32'(busy), 32'd0);

      // Unexpected address, then flags must stay sticky
      do_start(1);
      store(32'd104, 32'd25);
      chk("t2_code", 32'(fail_code), 32'd1);
      chk("t2_addr", fail_addr, 32'd104);
      store(32'd100, 32'd25);
      chk("t2_sticky_code", 32'(fail_code), 32'd1);
      chk("t2_sticky_fail", 32'(fail), 32'd1);

      // Data mismatch
      do_start(1);
      store(32'd100, 32'd24);
      chk("t3_code", 32'(fail_code), 32'd2);
      chk("t3_data", fail_data, 32'd24);

      // Timeout after exactly TO cycles, then a completing match on the limit edge
      do_start(1);
      for (int i = 0; i < TO - 1; i++) step();
      chk("t4_not_yet", 32'(fail), 32'd0);
      step();
      chk("t4_timeout", 32'(fail_code), 32'd3);
      chk("t4_addr0", fail_addr, 32'd0);
      do_start(1);
      for (int i = 0; i < TO - 1; i++) step();
      store(32'd100, 32'd25);
      chk("t4_match_wins", 32'(pass), 32'd1);

      // Ordered multi-entry check
      cfg_write(0, 32'd8, 32'd1);
      cfg_write(1, 32'd12, 32'd2);
      cfg_write(2, 32'd16, 32'd3);
      do_start(3);
      store(32'd8, 32'd1);
      store(32'd16, 32'd3);
      chk("t5_out_of_order", 32'(fail_code), 32'd1);
      chk("t5_match_cnt", 32'(match_cnt), 32'd1);
      do_start(3);
      store(32'd8, 32'd1);
      store(32'd12, 32'd2);
      store(32'd16, 32'd3);
      chk("t5_pass", 32'(pass), 32'd1);
      chk("t5_match3", 32'(match_cnt), 32'd3);

      // Reset mid-run
      do_start(3);
      store(32'd8, 32'd1);
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      chk("rst_mid_busy", 32'(busy), 32'd0);
      chk("rst_mid_match", 32'(match_cnt), 32'd0);

      // Empty table passes immediately
      do_start(0);
      chk("cnt0_pass", 32'(pass), 32'd1);

      // Table writes while busy are dropped
      do_start(3);
      cfg_write(0, 32'd200, 32'd9);
      store(32'd8, 32'd1);
      store(32'd12, 32'd2);
      store(32'd16, 32'd3);
      chk("busy_wr_pass", 32'(pass), 32'd1);

      // Randomized runs
      for (int r = 0; r < 60; r++) begin
         repeat ($urandom_range(0, 3))
            cfg_write(int'($urandom_range(0, 7)), pick_addr(), 32'($urandom_range(0, 3)));
         if ($urandom_range(0, 1) == 1)
            scr_write(int'($urandom_range(0, 1)), pick_addr(), 1'($urandom_range(0, 1)));
         if ($urandom_range(0, 3) == 0) begin
            cfg_we = 1'b1; cfg_idx = 3'd0; cfg_addr = pick_addr(); cfg_data = 32'($urandom_range(0, 3));
         end
         do_start(int'($urandom_range(0, 4)));
         for (int c = 0; c < TO + 4 && m_state == M_RUN; c++) begin
            case ($urandom_range(0, 9))
               0, 1, 2, 3, 4, 5: begin
                  if (exp_q.size() > 0) begin
                     MemWrite = 1'b1; DataAdr = exp_q[0].a; WriteData = exp_q[0].d;
                  end
               end
               6: begin
                  MemWrite = 1'b1; DataAdr = pick_addr(); WriteData = 32'($urandom_range(0, 3));
               end
               7: begin
                  cfg_we = 1'b1; cfg_idx = 3'($urandom_range(0, 7)); cfg_addr = pick_addr();
                  cfg_data = 32'($urandom_range(0, 3)); start = 1'b1; cfg_count = 4'($urandom_range(0, 4));
                  scr_we = 1'b1; scr_idx = 1'($urandom_range(0, 1)); scr_addr = pick_addr(); scr_en = 1'b1;
               end
               default: ;
            endcase
            step();
         end
         step();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
